// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the framed PISO transmitter: state encodings,
// line levels and a counter-width helper.
package piso_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/piso_serial_tx_d_ff.sv
// D flip-flop bank with synchronous active-low reset to a configurable value.
module d_ff_sync_rst_low #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Storage: reset wins over the data input at the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed LSB-first serial transmitter: start(0), WIDTH data bits, stop(1),
// each bit held DIV clocks. All state lives in d_ff_sync_rst_low instances.
module piso_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             RE,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             TX,
  output logic             BUSY,
  output logic             DONE
);
  import piso_serial_tx_pkg::*;

  localparam int             DVW      = cnt_width(DIV);
  localparam int             BCW      = cnt_width(WIDTH + 1);
  localparam logic [DVW-1:0] DIV_TC   = DVW'(DIV - 1);
  localparam logic [DVW-1:0] DIV_ONE  = DVW'(1);
  localparam logic [DVW-1:0] DIV_ZERO = {DVW{1'b0}};
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BIT_ZERO = {BCW{1'b0}};

  logic [1:0]       r_state;
  logic [DVW-1:0]   r_div;
  logic [BCW-1:0]   r_bit;
  logic [WIDTH-1:0] r_sh;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [DVW-1:0]   w_div_nxt;
  logic [BCW-1:0]   w_bit_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_sh_shift;
  logic             w_tx_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_div_tc;
  logic             w_last_bit;
  logic             w_accept;

  // With DIV=1 the divider stays at 0 and the terminal count is always true.
  assign w_div_tc   = (r_div == DIV_TC);
  assign w_last_bit = (r_bit == LAST_BIT);
  assign w_accept   = LOAD && !r_busy;
  assign w_sh_shift = r_sh >> 1;

  d_ff_sync_rst_low #(.W(2), .RST_VAL(2'd0)) u_state (
    .i_clk(C), .i_rst_n(RE), .i_d(w_state_nxt), .o_q(r_state));
  d_ff_sync_rst_low #(.W(DVW), .RST_VAL(DIV_ZERO)) u_div (
    .i_clk(C), .i_rst_n(RE), .i_d(w_div_nxt), .o_q(r_div));
  d_ff_sync_rst_low #(.W(BCW), .RST_VAL(BIT_ZERO)) u_bit (
    .i_clk(C), .i_rst_n(RE), .i_d(w_bit_nxt), .o_q(r_bit));
  d_ff_sync_rst_low #(.W(WIDTH), .RST_VAL({WIDTH{1'b0}})) u_sh (
    .i_clk(C), .i_rst_n(RE), .i_d(w_sh_nxt), .o_q(r_sh));
  d_ff_sync_rst_low #(.W(1), .RST_VAL(MARK)) u_tx (
    .i_clk(C), .i_rst_n(RE), .i_d(w_tx_nxt), .o_q(r_tx));
  d_ff_sync_rst_low #(.W(1), .RST_VAL(1'b0)) u_busy (
    .i_clk(C), .i_rst_n(RE), .i_d(w_busy_nxt), .o_q(r_busy));
  d_ff_sync_rst_low #(.W(1), .RST_VAL(1'b0)) u_done (
    .i_clk(C), .i_rst_n(RE), .i_d(w_done_nxt), .o_q(r_done));

  // Next-state: advance a phase whenever the divider reaches terminal count.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_START;
        else          w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_div_tc) w_state_nxt = ST_DATA;
        else          w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_div_tc && w_last_bit) w_state_nxt = ST_STOP;
        else                        w_state_nxt = ST_DATA;
      end
      ST_STOP: begin
        if (w_div_tc) w_state_nxt = ST_IDLE;
        else          w_state_nxt = ST_STOP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next data/outputs: TX is registered one bit ahead, so r_sh[0] is the bit on the line.
  always_comb begin
    w_tx_nxt   = r_tx;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_div_nxt  = r_div;
    w_bit_nxt  = r_bit;
    w_sh_nxt   = r_sh;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sh_nxt   = D;
          w_tx_nxt   = SPACE;
          w_busy_nxt = 1'b1;
          w_div_nxt  = DIV_ZERO;
          w_bit_nxt  = BIT_ZERO;
        end else begin
          w_tx_nxt   = MARK;
          w_busy_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (w_div_tc) begin
          w_tx_nxt  = r_sh[0];
          w_div_nxt = DIV_ZERO;
          w_bit_nxt = BIT_ZERO;
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      ST_DATA: begin
        if (w_div_tc) begin
          w_div_nxt = DIV_ZERO;
          if (w_last_bit) begin
            w_tx_nxt = MARK;
          end else begin
            w_tx_nxt  = w_sh_shift[0];
            w_sh_nxt  = w_sh_shift;
            w_bit_nxt = r_bit + BIT_ONE;
          end
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      ST_STOP: begin
        if (w_div_tc) begin
          w_tx_nxt   = MARK;
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          w_div_nxt  = DIV_ZERO;
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      default: begin
        w_tx_nxt   = MARK;
        w_busy_nxt = 1'b0;
        w_div_nxt  = DIV_ZERO;
        w_bit_nxt  = BIT_ZERO;
      end
    endcase
  end

  assign TX   = r_tx;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: WIDTH=8/DIV=4 instance plus a WIDTH=4/DIV=1 instance.
module tb_piso_serial_tx;

  logic       clk;
  logic       re;
  logic [7:0] d8;
  logic       load8;
  logic       tx8, busy8, done8;
  logic [3:0] d4;
  logic       load4;
  logic       tx4, busy4, done4;

  int checks = 0;
  int errors = 0;
  int hi_run = 0;

  typedef struct packed {
    logic       load;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[42];

  piso_serial_tx #(.WIDTH(8), .DIV(4)) dut8 (
    .C(clk), .RE(re), .D(d8), .LOAD(load8), .TX(tx8), .BUSY(busy8), .DONE(done8));
  piso_serial_tx #(.WIDTH(4), .DIV(1)) dut4 (
    .C(clk), .RE(re), .D(d4), .LOAD(load4), .TX(tx4), .BUSY(busy4), .DONE(done4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slots: bit s of 'slots' is the line level during serial bit s (start..stop).
  task automatic fill_frame(input logic [9:0] slots, input logic [7:0] data, input int extra_load_cycle);
    for (int i = 0; i < 42; i++) begin
      int c;
      c = i + 1;
      vecs[i].load = (i == 0) || (c == extra_load_cycle);
      vecs[i].d    = (i == 0) ? data : 8'hFF;
      vecs[i].tx   = (c <= 40) ? slots[(c - 1) / 4] : 1'b1;
      vecs[i].busy = (c <= 40);
      vecs[i].done = (c == 41);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 42; i++) begin
      load8 = vecs[i].load;
      d8    = vecs[i].d;
      tick();
      chk({name, "_tx"},   tx8,   vecs[i].tx);
      chk({name, "_busy"}, busy8, vecs[i].busy);
      chk({name, "_done"}, done8, vecs[i].done);
    end
    load8 = 1'b0;
  endtask

  // Called while sampling cycle 1 of a frame; returns while sampling the DONE cycle.
  task automatic expect_frame(input string name, input logic [9:0] slots);
    for (int c = 1; c <= 40; c++) begin
      chk({name, "_tx"},   tx8,   slots[(c - 1) / 4]);
      chk({name, "_busy"}, busy8, 1'b1);
      chk({name, "_done"}, done8, 1'b0);
      if (tx8 === 1'b1) hi_run++;
      else              hi_run = 0;
      tick();
    end
    chk({name, "_end_tx"},   tx8,   1'b1);
    chk({name, "_end_busy"}, busy8, 1'b0);
    chk({name, "_end_done"}, done8, 1'b1);
    if (tx8 === 1'b1) hi_run++;
    else              hi_run = 0;
  endtask

  logic exp4 [7];
  int   done_seen;

  initial begin
    re = 1'b0; load8 = 1'b1; d8 = 8'hFF; load4 = 1'b0; d4 = 4'h0;

    // Reset with LOAD asserted: reset must win.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_tx", tx8, 1'b1);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
    end
    chk("rst4_tx", tx4, 1'b1);
    load8 = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle_tx", tx8, 1'b1);
      chk("post_rst_idle_busy", busy8, 1'b0);
    end

    // Single A5 frame, then A5 with an ignored LOAD of FF at cycle 10.
    fill_frame(10'b1101001010, 8'hA5, 0);
    run_table("a5");
    fill_frame(10'b1101001010, 8'hA5, 10);
    run_table("a5_busyload");

    // Back-to-back: LOAD held, 00 then 81 presented in the DONE cycle.
    load8 = 1'b1; d8 = 8'h00;
    tick();
    hi_run = 0;
    expect_frame("b2b_00", 10'b1000000000);
    chk("b2b_gap", hi_run, 5);
    d8 = 8'h81;
    tick();
    load8 = 1'b0;
    expect_frame("b2b_81", 10'b1100000010);
    tick();

    // Abort an in-flight 3C frame at cycle 15.
    load8 = 1'b1; d8 = 8'h3C;
    tick();
    load8 = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("abort_pre_busy", busy8, 1'b1);
    re = 1'b0;
    tick();
    re = 1'b1;
    chk("abort_tx", tx8, 1'b1);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) done_seen++;
    end
    chk("abort_quiet", done_seen, 0);
    load8 = 1'b1; d8 = 8'h3C;
    tick();
    load8 = 1'b0;
    expect_frame("reload_3c", 10'b1001111000);
    tick();

    // WIDTH=4, DIV=1 instance with 4'b0110.
    exp4 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    load4 = 1'b1; d4 = 4'b0110;
    tick();
    load4 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("w4_tx", tx4, exp4[c - 1]);
      chk("w4_busy", busy4, (c <= 6) ? 1'b1 : 1'b0);
      chk("w4_done", done4, (c == 7) ? 1'b1 : 1'b0);
      tick();
    end
    chk("w4_idle_done", done4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
